// File: rtl/sdram_scan_pkg.sv
// Shared types, constants and min/max seed helpers for the SDRAM scan master.
// Seeds are returned 64 bits wide; callers keep the low DATA_W bits.
package sdram_scan_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} scan_state_t;

  localparam int unsigned SDRAM_BASE = 0;

  function automatic logic [63:0] min_init(input int data_w, input bit signed_cmp);
    logic [63:0] ones;
    ones = {64{1'b1}} >> (64 - data_w);
    return signed_cmp ? (ones >> 1) : ones;
  endfunction

  function automatic logic [63:0] max_init(input int data_w, input bit signed_cmp);
    return signed_cmp ? (64'd1 << (data_w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/sdram_scan_acc.sv
// Min/max/beat-count accumulator for the scan master; the optional running sum
// is built only when SDRAM_SCAN_SUM_EN is defined.
module sdram_scan_acc
  import sdram_scan_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 16,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] max,
  output logic [LEN_W-1:0]  count
`ifdef SDRAM_SCAN_SUM_EN
  ,
  output logic [DATA_W+LEN_W-1:0] sum
`endif
);

  // Reset always shows the unsigned image; a start seeds for the active compare mode.
  localparam logic [63:0] MIN_RST_W = min_init(DATA_W, 1'b0);
  localparam logic [63:0] MAX_RST_W = max_init(DATA_W, 1'b0);
  localparam logic [63:0] MIN_SET_W = min_init(DATA_W, SIGNED_CMP != 0);
  localparam logic [63:0] MAX_SET_W = max_init(DATA_W, SIGNED_CMP != 0);
  localparam logic [DATA_W-1:0] MIN_RST = MIN_RST_W[DATA_W-1:0];
  localparam logic [DATA_W-1:0] MAX_RST = MAX_RST_W[DATA_W-1:0];
  localparam logic [DATA_W-1:0] MIN_SET = MIN_SET_W[DATA_W-1:0];
  localparam logic [DATA_W-1:0] MAX_SET = MAX_SET_W[DATA_W-1:0];

  logic lt_min;
  logic gt_max;

  always_comb begin
    if (SIGNED_CMP != 0) begin
      lt_min = $signed(data) < $signed(min);
      gt_max = $signed(data) > $signed(max);
    end else begin
      lt_min = data < min;
      gt_max = data > max;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min   <= MIN_RST;
      max   <= MAX_RST;
      count <= '0;
    end else if (clear) begin
      min   <= MIN_SET;
      max   <= MAX_SET;
      count <= '0;
    end else if (valid) begin
      if (lt_min) min <= data;
      if (gt_max) max <= data;
      count <= count + LEN_W'(1);
    end
  end

`ifdef SDRAM_SCAN_SUM_EN
  logic [DATA_W+LEN_W-1:0] data_ext;

  assign data_ext = (SIGNED_CMP != 0) ? {{LEN_W{data[DATA_W-1]}}, data}
                                      : {{LEN_W{1'b0}}, data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   sum <= '0;
    else if (clear) sum <= '0;
    else if (valid) sum <= sum + data_ext;
  end
`endif

endmodule

// File: rtl/sdram_scan_master.sv
// Avalon-MM pipelined read master that scans a window of SDRAM words and reports
// min/max/count. Defining SDRAM_SCAN_SUM_EN adds the sum output.
module sdram_scan_master
  import sdram_scan_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_OUTST  = 4,
  parameter int ADDR_STEP  = 1,
  parameter int SIGNED_CMP = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_words,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   min,
  output logic [DATA_W-1:0]   max,
  output logic [LEN_W-1:0]    count,
  output logic [ADDR_W-1:0]   address,
  output logic                read_n,
  output logic                write_n,
  output logic                chipselect,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic                waitrequest,
  input  logic                readdatavalid,
  input  logic [DATA_W-1:0]   readdata
`ifdef SDRAM_SCAN_SUM_EN
  ,
  output logic [DATA_W+LEN_W-1:0] sum
`endif
);

  localparam int OUT_W = 4;

  scan_state_t       state, state_next;
  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  issued, issued_next;
  logic [LEN_W-1:0]  num_q, num_next;
  logic [OUT_W-1:0]  outst, outst_next;
  logic              read_n_next, busy_next, done_next;
  logic              start_ok, accept, beat;

  assign write_n    = 1'b1;
  assign chipselect = 1'b1;
  assign byteenable = '1;
  assign writedata  = '0;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = !read_n && !waitrequest;
  // Beats outside an active scan, or beyond the requested length, are dropped.
  assign beat     = readdatavalid && ((state == ISSUE) || (state == DRAIN)) && (count != num_q);

  always_comb begin
    state_next  = state;
    addr_next   = address;
    issued_next = issued;
    outst_next  = outst;
    num_next    = num_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          addr_next   = base_addr;
          issued_next = '0;
          outst_next  = '0;
          num_next    = num_words;
          state_next  = (num_words == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_next   = address + ADDR_W'(ADDR_STEP);
          issued_next = issued + LEN_W'(1);
          if (issued_next == num_q) state_next = DRAIN;
        end
        outst_next = outst + OUT_W'(accept) - OUT_W'(beat);
      end
      DRAIN: begin
        outst_next = outst - OUT_W'(beat);
        if (beat && (count + LEN_W'(1) == num_q)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    // A stalled request keeps read_n low since neither issued nor outstanding can grow.
    read_n_next = !((state_next == ISSUE) && (issued_next < num_next) &&
                    (outst_next < OUT_W'(MAX_OUTST)));
    busy_next   = (state_next == ISSUE) || (state_next == DRAIN);
    done_next   = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      address <= ADDR_W'(SDRAM_BASE);
      read_n  <= 1'b1;
      issued  <= '0;
      outst   <= '0;
      num_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      address <= addr_next;
      read_n  <= read_n_next;
      issued  <= issued_next;
      outst   <= outst_next;
      num_q   <= num_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  sdram_scan_acc #(
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .SIGNED_CMP(SIGNED_CMP)
  ) u_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (start_ok),
    .valid  (beat),
    .data   (readdata),
    .min    (min),
    .max    (max),
    .count  (count)
`ifdef SDRAM_SCAN_SUM_EN
    ,
    .sum    (sum)
`endif
  );

endmodule

// File: tb/tb_sdram_scan_master.sv
// Directed bench for sdram_scan_master: unsigned and signed instances share one
// Avalon slave model with configurable stalls and latency.
module tb_sdram_scan_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        waitrequest = 1'b0;
  logic        readdatavalid = 1'b0;
  logic [15:0] readdata = '0;

  logic        busy, done, read_n, write_n, chipselect;
  logic [15:0] min, max, count, writedata;
  logic [31:0] address;
  logic [1:0]  byteenable;
  logic        s_busy, s_done, s_read_n, s_write_n, s_chipselect;
  logic [15:0] s_min, s_max, s_count, s_writedata;
  logic [31:0] s_address;
  logic [1:0]  s_byteenable;
`ifdef SDRAM_SCAN_SUM_EN
  logic [31:0] sum, s_sum;
`endif

  always #5 clk = ~clk;

  sdram_scan_master u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .min(min), .max(max),
    .count(count), .address(address), .read_n(read_n), .write_n(write_n),
    .chipselect(chipselect), .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata)
`ifdef SDRAM_SCAN_SUM_EN
    , .sum(sum)
`endif
  );

  sdram_scan_master #(.SIGNED_CMP(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(s_busy), .done(s_done), .min(s_min), .max(s_max),
    .count(s_count), .address(s_address), .read_n(s_read_n), .write_n(s_write_n),
    .chipselect(s_chipselect), .byteenable(s_byteenable), .writedata(s_writedata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata)
`ifdef SDRAM_SCAN_SUM_EN
    , .sum(s_sum)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] data_tbl [16];
  logic [31:0] cur_base = '0;
  bit          stall_mode = 1'b0;
  int          lat = 1;
  int          cyc = 0;
  int          req_idx = 0;
  int          stall_done = 0;
  int          stalls = 0;
  int          stable_err = 0;
  int          read_low = 0;
  int          peak = 0;
  int          done_cyc = 0;
  int          last_beat_cyc = 0;
  bit          done_prev = 1'b0;
  bit          stall_watch = 1'b0;
  logic [31:0] stall_addr = '0;
  int          pend_due [$];
  logic [15:0] pend_data [$];
  logic [31:0] acc_addr [$];

  // Slave model: decides waitrequest/readdatavalid on the falling edge so the DUT
  // samples settled values on the next rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done === 1'b1 && !done_prev) done_cyc = cyc;
    done_prev = (done === 1'b1);
    if (stall_watch && (read_n !== 1'b0 || address !== stall_addr)) stable_err = stable_err + 1;
    stall_watch = 1'b0;
    readdatavalid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      readdatavalid = 1'b1;
      readdata = pend_data.pop_front();
      void'(pend_due.pop_front());
      last_beat_cyc = cyc;
    end
    waitrequest = 1'b0;
    if (reset_n === 1'b1 && read_n === 1'b0) begin
      read_low = read_low + 1;
      if (stall_mode && req_idx[0] && stall_done < 3) begin
        waitrequest = 1'b1;
        stall_done  = stall_done + 1;
        stalls      = stalls + 1;
        stall_watch = 1'b1;
        stall_addr  = address;
      end else begin
        pend_due.push_back(cyc + lat);
        pend_data.push_back(data_tbl[4'(address - cur_base)]);
        acc_addr.push_back(address);
        req_idx    = req_idx + 1;
        stall_done = 0;
      end
    end
    if (pend_due.size() > peak) peak = pend_due.size();
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [15:0] n, input bit stl, input int l);
    @(posedge clk); #1;
    cur_base = b; stall_mode = stl; lat = l;
    req_idx = 0; stall_done = 0; stalls = 0; stable_err = 0;
    read_low = 0; peak = 0; acc_addr.delete();
    base_addr = b; num_words = n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("busy_after_start", busy, n != 0);
    checkOutput("done_after_start", done, n == 0);
    checkOutput("read_n_after_start", read_n, n == 0);
  endtask

  task automatic waitForDone(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput(tag, done, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_read_n", read_n, 1);
    checkOutput("rst_write_n", write_n, 1);
    checkOutput("rst_chipselect", chipselect, 1);
    checkOutput("rst_byteenable", byteenable, 2'b11);
    checkOutput("rst_writedata", writedata, 0);
    checkOutput("rst_address", address, 0);
    checkOutput("rst_busy_done", {busy, done}, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_min", min, 16'hFFFF);
    checkOutput("rst_max", max, 0);
    checkOutput("rst_s_min", s_min, 16'hFFFF);
    checkOutput("rst_s_max", s_max, 0);
    reset_n = 1'b1;

    // Empty scan
    applyStimulus(32'h1234, 16'd0, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("zero_read_low", read_low, 0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_min", min, 16'hFFFF);
    checkOutput("zero_max", max, 0);
    checkOutput("zero_count", count, 0);
    checkOutput("zero_s_min", s_min, 16'h7FFF);
    checkOutput("zero_s_max", s_max, 16'h8000);

    // Ten words, zero wait states
    data_tbl = '{16'h5, 16'h3, 16'h9, 16'h8000, 16'h7, 16'h1, 16'h2, 16'h2,
                 16'h4, 16'h6, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    applyStimulus(32'h0, 16'd10, 1'b0, 1);
    waitForDone("t1_done_timeout");
    checkOutput("t1_min", min, 16'h1);
    checkOutput("t1_max", max, 16'h8000);
    checkOutput("t1_count", count, 10);
    checkOutput("t1_s_min", s_min, 16'h8000);
    checkOutput("t1_s_max", s_max, 16'h9);
    checkOutput("t1_done_delay", done_cyc - last_beat_cyc, 1);
    checkOutput("t1_busy", busy, 0);

    // Sixteen words with stalls on every second request, latency 6
    for (int i = 0; i < 16; i++) data_tbl[i] = 16'(i * 7 + 2);
    applyStimulus(32'h40, 16'd16, 1'b1, 6);
    repeat (5) @(negedge clk);
    num_words = 16'd3; base_addr = 32'h0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("t2_busy_ignore_start", busy, 1);
    waitForDone("t2_done_timeout");
    checkOutput("t2_count", count, 16);
    checkOutput("t2_min", min, 16'd2);
    checkOutput("t2_max", max, 16'd107);
    checkOutput("t2_num_accepts", acc_addr.size(), 16);
    for (int i = 0; i < acc_addr.size(); i++)
      checkOutput("t2_addr", acc_addr[i], 32'(32'h40 + 32'(i)));
    checkOutput("t2_stalls", stalls, 24);
    checkOutput("t2_stable", stable_err, 0);
    checkOutput("t2_outst_le_max", peak <= 4, 1);

    // Outstanding limit with long latency and address wrap
    data_tbl = '{16'h7FFF, 16'h0010, 16'hFFFE, 16'h0003, 16'h8001, 16'h1234, 16'h0000, 16'h00FF,
                 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    applyStimulus(32'hFFFF_FFFE, 16'd8, 1'b0, 10);
    waitForDone("t3_done_timeout");
    checkOutput("t3_peak_outst", peak, 4);
    checkOutput("t3_num_accepts", acc_addr.size(), 8);
    for (int i = 0; i < acc_addr.size(); i++)
      checkOutput("t3_addr", acc_addr[i], 32'(32'hFFFF_FFFE + 32'(i)));
    checkOutput("t3_count", count, 8);
    checkOutput("t3_min", min, 16'h0000);
    checkOutput("t3_max", max, 16'hFFFE);
    checkOutput("t3_s_min", s_min, 16'h8001);
    checkOutput("t3_s_max", s_max, 16'h7FFF);
    checkOutput("t3_done_delay", done_cyc - last_beat_cyc, 1);

    // Reset in the middle of a scan, then a fresh two-word scan
    for (int i = 0; i < 16; i++) data_tbl[i] = 16'(16'h0500 + i);
    applyStimulus(32'h200, 16'd8, 1'b0, 6);
    begin
      int k;
      k = 0;
      while (count != 16'd3 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
    end
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_read_n", read_n, 1);
    checkOutput("mid_rst_address", address, 0);
    checkOutput("mid_rst_busy_done", {busy, done}, 0);
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_min", min, 16'hFFFF);
    checkOutput("mid_rst_max", max, 0);
    checkOutput("mid_rst_s_min", s_min, 16'hFFFF);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("late_count", count, 0);
    checkOutput("late_min", min, 16'hFFFF);
    checkOutput("late_max", max, 0);
    checkOutput("late_busy_done", {busy, done}, 0);
    data_tbl[0] = 16'h0042;
    data_tbl[1] = 16'hFFF0;
    applyStimulus(32'h10, 16'd2, 1'b0, 1);
    waitForDone("t4_done_timeout");
    checkOutput("t4_count", count, 2);
    checkOutput("t4_min", min, 16'h0042);
    checkOutput("t4_max", max, 16'hFFF0);
    checkOutput("t4_s_min", s_min, 16'hFFF0);
    checkOutput("t4_s_max", s_max, 16'h0042);

`ifdef SDRAM_SCAN_SUM_EN
    data_tbl[0] = 16'hFFFF;
    data_tbl[1] = 16'hFFFF;
    data_tbl[2] = 16'h0002;
    applyStimulus(32'h0, 16'd3, 1'b0, 1);
    waitForDone("sum_done_timeout");
    checkOutput("sum_unsigned", sum, 32'h0002_0000);
    checkOutput("sum_signed", s_sum, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
